run_sequencer: RTL and testbench

RUN_SEQUENCER -- requirements
Module: run_sequencer

---
 rtl/run_sequencer.sv | 141 ++++++++++++++
 tb/tb_run_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// run_sequencer: start/reset/run/done sequencer that frames one processor run.
// Ports: clk, rst (sync, active-low), start, halt_req -> core_rst, cycle[31:0],
//   running, done, timeout. Optional macro RUN_TIMEOUT_EN ends a run at MAX_CYCLES.
module run_sequencer #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter logic [31:0] MAX_CYCLES   = 32'd500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  output logic        core_rst,
  output logic [31:0] cycle,
  output logic        running,
  output logic        done,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [7:0] RC_LAST = 8'(RESET_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nx;
  logic        r_core_rst;
  logic        w_core_rst_nx;
  logic [31:0] r_cycle;
  logic [31:0] w_cycle_nx;
  logic        r_running;
  logic        w_running_nx;
  logic        r_done;
  logic        w_done_nx;
  logic        r_timeout;
  logic        w_timeout_nx;
  logic [7:0]  r_rcnt;
  logic [7:0]  w_rcnt_nx;
  logic [31:0] w_cycle_inc;

  // Count saturates instead of wrapping to 0.
  assign w_cycle_inc = (r_cycle == 32'hFFFF_FFFF) ? r_cycle
                                                  : r_cycle + 32'd1;

`ifndef RUN_TIMEOUT_EN
  logic w_unused_max;
  assign w_unused_max = ^MAX_CYCLES;
`endif

  always_comb begin
    w_state_nx    = r_state;
    w_core_rst_nx = r_core_rst;
    w_cycle_nx    = r_cycle;
    w_running_nx  = r_running;
    w_done_nx     = r_done;
    w_timeout_nx  = r_timeout;
    w_rcnt_nx     = r_rcnt;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        w_core_rst_nx = 1'b1;
        w_running_nx  = 1'b0;
        if (start) begin
          w_state_nx   = S_RESET;
          w_cycle_nx   = 32'd0;
          w_done_nx    = 1'b0;
          w_timeout_nx = 1'b0;
          w_rcnt_nx    = 8'd0;
        end
      end
      S_RESET: begin
        w_core_rst_nx = 1'b1;
        w_running_nx  = 1'b0;
        w_rcnt_nx     = r_rcnt + 8'd1;
        // Leave on the last counted clock so core_rst spans
        // exactly RESET_CYCLES clocks.
        if (r_rcnt == RC_LAST) begin
          w_state_nx    = S_RUN;
          w_core_rst_nx = 1'b0;
          w_running_nx  = 1'b1;
        end
      end
      S_RUN: begin
        w_core_rst_nx = 1'b0;
        w_running_nx  = 1'b1;
        if (halt_req) begin
          // Halt wins over the limit; the count does not advance.
          w_state_nx    = S_DONE;
          w_core_rst_nx = 1'b1;
          w_running_nx  = 1'b0;
          w_done_nx     = 1'b1;
        end else begin
          w_cycle_nx = w_cycle_inc;
`ifdef RUN_TIMEOUT_EN
          if (w_cycle_inc == MAX_CYCLES) begin
            w_state_nx    = S_DONE;
            w_core_rst_nx = 1'b1;
            w_running_nx  = 1'b0;
            w_done_nx     = 1'b1;
            w_timeout_nx  = 1'b1;
          end
`endif
        end
      end
      default: begin
        w_state_nx    = S_IDLE;
        w_core_rst_nx = 1'b1;
        w_running_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_core_rst <= 1'b1;
      r_cycle    <= 32'd0;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_rcnt     <= 8'd0;
    end else begin
      r_state    <= w_state_nx;
      r_core_rst <= w_core_rst_nx;
      r_cycle    <= w_cycle_nx;
      r_running  <= w_running_nx;
      r_done     <= w_done_nx;
      r_timeout  <= w_timeout_nx;
      r_rcnt     <= w_rcnt_nx;
    end
  end

  assign core_rst = r_core_rst;
  assign cycle    = r_cycle;
  assign running  = r_running;
  assign done     = r_done;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench for run_sequencer: stimulus queues expected snapshots,
// a negedge monitor compares them when done rises or on request.
module tb_run_sequencer;

`ifdef RUN_TIMEOUT_EN
  localparam logic [31:0] TB_MAX = 32'd8;
`else
  localparam logic [31:0] TB_MAX = 32'd500;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        core_rst;
  logic [31:0] cycle;
  logic        running;
  logic        done;
  logic        timeout;

  run_sequencer #(
    .RESET_CYCLES(2),
    .MAX_CYCLES  (TB_MAX)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .halt_req(halt_req),
    .core_rst(core_rst),
    .cycle   (cycle),
    .running (running),
    .done    (done),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        core_rst;
    logic [31:0] cycle;
    logic        running;
    logic        done;
    logic        timeout;
    bit          has_len;
    int          rst_len;
    int          run_len;
  } exp_t;

  exp_t q_now[$];
  exp_t q_done[$];
  exp_t me;

  int n_asrt = 0;
  int n_fail = 0;
  int pre_cnt = 0;
  int run_cnt = 0;
  logic prev_done = 1'b0;

  task automatic cmp(input int id, input string f,
                     input logic [31:0] act, input logic [31:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL chk%0d %s: got %0h expected %0h", id, f, act, exp);
    end
  endtask

  task automatic check_all(input exp_t e);
    cmp(e.id, "core_rst", 32'(core_rst), 32'(e.core_rst));
    cmp(e.id, "cycle", cycle, e.cycle);
    cmp(e.id, "running", 32'(running), 32'(e.running));
    cmp(e.id, "done", 32'(done), 32'(e.done));
    cmp(e.id, "timeout", 32'(timeout), 32'(e.timeout));
    if (e.has_len) begin
      cmp(e.id, "rst_len", 32'(pre_cnt), 32'(e.rst_len));
      cmp(e.id, "run_len", 32'(run_cnt), 32'(e.run_len));
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1 && prev_done !== 1'b1) begin
      if (q_done.size() == 0) begin
        n_asrt++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 cycle=%0h expected no run end",
                 cycle);
      end else begin
        me = q_done.pop_front();
        check_all(me);
      end
    end
    if (q_now.size() > 0) begin
      me = q_now.pop_front();
      check_all(me);
    end
    if (start && !running) begin
      pre_cnt = 0;
      run_cnt = 0;
    end else if (running) begin
      run_cnt++;
    end else if (core_rst) begin
      pre_cnt++;
    end
    prev_done = done;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_now(input int id, input logic cr, input logic [31:0] cy,
                         input logic rn, input logic dn, input logic to);
    exp_t e;
    e.id = id; e.core_rst = cr; e.cycle = cy; e.running = rn;
    e.done = dn; e.timeout = to; e.has_len = 0;
    e.rst_len = 0; e.run_len = 0;
    q_now.push_back(e);
  endtask

  task automatic exp_done(input int id, input logic [31:0] cy,
                          input logic to, input int rl);
    exp_t e;
    e.id = id; e.core_rst = 1'b1; e.cycle = cy; e.running = 1'b0;
    e.done = 1'b1; e.timeout = to; e.has_len = 1;
    e.rst_len = 2; e.run_len = rl;
    q_done.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus expected finish");
    n_fail++;
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset for two clocks.
    tick(2);
    exp_now(1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    tick(1);
    rst = 1'b1;
    tick(1);
`ifndef RUN_TIMEOUT_EN
    // Basic run: halt on the 10th RUN edge.
    pulse_start();
    exp_done(2, 32'd9, 1'b0, 10);
    tick(11);
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    tick(2);
    // Restart from DONE clears the flags and count.
    pulse_start();
    exp_now(3, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    tick(5);
    // Start inside RUN is ignored.
    pulse_start();
    exp_now(4, 1'b0, 32'd4, 1'b1, 1'b0, 1'b0);
    tick(46);
    exp_now(5, 1'b0, 32'd50, 1'b1, 1'b0, 1'b0);
    // Mid-run reset.
    rst = 1'b0;
    tick(1);
    exp_now(6, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    // Halt outside RUN is ignored.
    halt_req = 1'b1;
    tick(2);
    halt_req = 1'b0;
    exp_now(7, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    tick(1);
    // Halt on the very first RUN edge.
    pulse_start();
    exp_done(8, 32'd0, 1'b0, 1);
    tick(2);
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    tick(2);
    // Saturation at the top of the count.
    pulse_start();
    tick(3);
    force dut.r_cycle = 32'hFFFF_FFFE;
    #1;
    release dut.r_cycle;
    tick(2);
    exp_now(9, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    exp_done(11, 32'hFFFF_FFFF, 1'b0, 5);
    tick(1);
    exp_now(10, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    tick(2);
`else
    // Limit reached with no halt.
    pulse_start();
    exp_done(20, 32'd8, 1'b1, 8);
    tick(14);
    // Halt on the limit edge wins.
    pulse_start();
    exp_done(21, 32'd7, 1'b0, 8);
    tick(9);
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    tick(2);
    // Restart clears timeout.
    pulse_start();
    exp_now(22, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    tick(3);
`endif
    tick(3);
    n_asrt++;
    if (q_now.size() != 0 || q_done.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0",
               q_now.size() + q_done.size());
    end
    summary();
    $finish;
  end

endmodule
